// File: rtl/mac_ctrl_pkg.sv
// Shared types and constants for the MAC array pass controller.
package mac_ctrl_pkg;

  localparam int unsigned DefRow     = 8;
  localparam int unsigned DefCol     = 8;
  localparam int unsigned DefCntBw   = 8;
  localparam int unsigned DefLoadGap = 16;

  typedef enum logic [2:0] {
    IDLE,
    KLOAD,
    KGAP,
    EXEC,
    DRAIN,
    DONE
  } state_e;

  localparam logic [1:0] INST_NOP = 2'b00;
  localparam logic [1:0] INST_KLD = 2'b01;
  localparam logic [1:0] INST_EXE = 2'b10;

endpackage

// File: rtl/mac_issue_cnt.sv
// Enable-gated up counter with synchronous clear; tc flags the enabled cycle at cnt == term.
module mac_issue_cnt #(
  parameter int unsigned width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [width-1:0] term,
  output logic             tc
);

  logic [width-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + width'(1);
    end
  end

  assign tc = en && (cnt_q == term);

endmodule

// File: rtl/mac_array_ctrl.sv
// Sequences one kernel-load / execute pass of the weight-stationary MAC array:
// pulls L0 words, drives inst_w and gates column valids into OFIFO writes.
module mac_array_ctrl
  import mac_ctrl_pkg::*;
#(
  parameter int unsigned row      = DefRow,
  parameter int unsigned col      = DefCol,
  parameter int unsigned cnt_bw   = DefCntBw,
  parameter int unsigned load_gap = DefLoadGap
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [cnt_bw-1:0] num_act,
  output logic              busy,
  output logic              done,
  input  logic              l0_empty,
  output logic              l0_rd,
  output logic [1:0]        inst_w,
  input  logic              ofifo_afull,
  input  logic [col-1:0]    col_valid,
  output logic [col-1:0]    ofifo_wr
);

  // Never let the gap drop below the inst_w flight time through the array.
  localparam int unsigned gap_cycles = (load_gap > row + col) ? load_gap : row + col;
  localparam int unsigned kw = (col > 1) ? $clog2(col) : 1;
  localparam int unsigned gw = $clog2(gap_cycles + 1);

  state_e            state_q, state_d;
  logic [cnt_bw-1:0] act_tgt_q, act_tgt_d;
  logic [cnt_bw-1:0] act_term;
  logic              ocnt_hit_q, ocnt_hit_d;

  logic cnt_clr, k_issue, a_issue, g_en, o_en;
  logic k_tc, g_tc, a_tc, o_tc;

  assign cnt_clr  = (state_q == IDLE);
  assign k_issue  = (state_q == KLOAD) && !l0_empty;
  assign a_issue  = (state_q == EXEC) && !l0_empty && !ofifo_afull;
  assign g_en     = (state_q == KGAP);
  assign o_en     = ((state_q == EXEC) || (state_q == DRAIN)) && col_valid[col-1];
  assign act_term = act_tgt_q - cnt_bw'(1);

  mac_issue_cnt #(.width(kw)) u_kcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (k_issue),
    .term  (kw'(col - 1)),
    .tc    (k_tc)
  );

  mac_issue_cnt #(.width(gw)) u_gcnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (g_en),
    .term  (gw'(gap_cycles - 1)),
    .tc    (g_tc)
  );

  mac_issue_cnt #(.width(cnt_bw)) u_acnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (a_issue),
    .term  (act_term),
    .tc    (a_tc)
  );

  mac_issue_cnt #(.width(cnt_bw)) u_ocnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (o_en),
    .term  (act_term),
    .tc    (o_tc)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      act_tgt_q  <= '0;
      ocnt_hit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      act_tgt_q  <= act_tgt_d;
      ocnt_hit_q <= ocnt_hit_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    act_tgt_d  = act_tgt_q;
    ocnt_hit_d = ocnt_hit_q || o_tc;
    busy       = 1'b1;
    done       = 1'b0;
    l0_rd      = 1'b0;
    inst_w     = INST_NOP;
    ofifo_wr   = '0;
    unique case (state_q)
      IDLE: begin
        busy       = 1'b0;
        ocnt_hit_d = 1'b0;
        if (start) begin
          act_tgt_d = num_act;
          state_d   = KLOAD;
        end
      end
      KLOAD: begin
        if (k_issue) begin
          l0_rd  = 1'b1;
          inst_w = INST_KLD;
          if (k_tc) state_d = KGAP;
        end
      end
      KGAP: begin
        if (g_tc) state_d = (act_tgt_q == '0) ? DRAIN : EXEC;
      end
      EXEC: begin
        ofifo_wr = col_valid;
        if (a_issue) begin
          l0_rd  = 1'b1;
          inst_w = INST_EXE;
          if (a_tc) state_d = DRAIN;
        end
      end
      DRAIN: begin
        ofifo_wr = col_valid;
        // ocnt may already have reached the target while still executing.
        if (o_tc || ocnt_hit_q || (act_tgt_q == '0)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_array_ctrl.sv
// Randomized bench for mac_array_ctrl against a count-level pass model with a simple array latency model.
module tb_mac_array_ctrl;
  import mac_ctrl_pkg::*;

  localparam int unsigned ROW = 8;
  localparam int unsigned COL = 8;
  localparam int unsigned CBW = 8;
  localparam int unsigned GAP = 16;

  logic           clk = 1'b0;
  logic           reset, start, busy, done, l0_empty, l0_rd, ofifo_afull;
  logic [CBW-1:0] num_act;
  logic [1:0]     inst_w;
  logic [COL-1:0] col_valid, ofifo_wr;

  always #5 clk = ~clk;

  mac_array_ctrl #(.row(ROW), .col(COL), .cnt_bw(CBW), .load_gap(GAP)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .num_act     (num_act),
    .busy        (busy),
    .done        (done),
    .l0_empty    (l0_empty),
    .l0_rd       (l0_rd),
    .inst_w      (inst_w),
    .ofifo_afull (ofifo_afull),
    .col_valid   (col_valid),
    .ofifo_wr    (ofifo_wr)
  );

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Pass model: counts of what the pass has done so far.
  bit          m_in = 0, m_fin = 0;
  int          m_kld = 0, m_gz = 0, m_exe = 0, m_outs = 0, m_tgt = 0;
  logic [31:0] hist = '0;
  bit          last_exe = 0;

  bit             rst_req = 1, start_req = 0, empty_tog = 0;
  logic [CBW-1:0] na_req = '0;
  int             empty_mode = 0, afull_mode = 0, afull_hold = 0;
  int             z_since = 0, d_kld = 0, d_exe = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    assert (act === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_in = 0; m_fin = 0; m_kld = 0; m_gz = 0; m_exe = 0; m_outs = 0;
  endtask

  task automatic check_cycle();
    logic [1:0]     ei;
    logic [COL-1:0] ew;
    bit             ed, outp, gapc, in0;
    int             exe0;
    in0  = m_in;
    exe0 = m_exe;
    outp = m_in && !m_fin && m_kld == COL && m_gz == GAP;
    gapc = m_in && !m_fin && m_kld == COL && m_gz < GAP;
    ed   = m_in && m_fin;
    ei   = INST_NOP;
    ew   = '0;
    if (m_in && !m_fin && m_kld < COL && !l0_empty) ei = INST_KLD;
    if (outp) begin
      ew = col_valid;
      if (m_exe < m_tgt && !l0_empty && !ofifo_afull) ei = INST_EXE;
    end
    chk("inst_w", 32'(inst_w), 32'(ei));
    chk("l0_rd", 32'(l0_rd), 32'(ei != INST_NOP));
    chk("busy", 32'(busy), 32'(m_in));
    chk("done", 32'(done), 32'(ed));
    chk("ofifo_wr", 32'(ofifo_wr), 32'(ew));
    if (inst_w == INST_EXE) chk("kld_exe_spacing", 32'(z_since >= GAP), 32'd1);
    if (inst_w == INST_KLD) z_since = 0;
    else if (inst_w == INST_NOP) z_since++;
    if (inst_w == INST_KLD) d_kld++;
    if (inst_w == INST_EXE) d_exe++;
    last_exe = (ei == INST_EXE);
    if (ei == INST_KLD) m_kld++;
    if (gapc) m_gz++;
    if (ei == INST_EXE) m_exe++;
    if (outp && col_valid[COL-1]) m_outs++;
    if (ed) begin
      chk("kld_count", 32'(d_kld), COL);
      chk("exe_count", 32'(d_exe), 32'(m_tgt));
      m_in = 0; m_fin = 0;
    end else if (outp && exe0 == m_tgt && m_outs >= m_tgt) begin
      m_fin = 1;
    end
    if (start && reset && !in0) begin
      model_clear();
      m_in = 1; m_tgt = int'(num_act); d_kld = 0; d_exe = 0;
    end
  endtask

  task automatic tick();
    logic [COL-1:0] cv;
    @(posedge clk);
    #1;
    if (!reset) model_clear();
    hist = {hist[30:0], last_exe};
    reset   = !rst_req;
    start   = start_req;
    num_act = na_req;
    empty_tog = !empty_tog;
    case (empty_mode)
      0:       l0_empty = 1'b0;
      1:       l0_empty = empty_tog;
      default: l0_empty = ($urandom_range(0, 9) < 3);
    endcase
    if (afull_hold > 0) begin
      ofifo_afull = 1'b1;
      afull_hold--;
    end else begin
      ofifo_afull = (afull_mode != 0) && ($urandom_range(0, 9) < 2);
    end
    for (int j = 0; j < COL; j++) cv[j] = hist[ROW + j - 1];
    col_valid = cv | (COL'($urandom) & {1'b0, {(COL - 1){1'b1}}});
    @(negedge clk);
    check_cycle();
  endtask

  task automatic run_pass(input int na, input int bp_at, input int rst_at, input bit spam,
                          input bit at_done);
    int guard = 0;
    bit bp_done = 0, rst_done = 0;
    na_req = CBW'(na);
    start_req = 1;
    tick();
    start_req = 0;
    while (m_in && guard < 3000) begin
      guard++;
      rst_req = 0;
      start_req = 0;
      if (bp_at >= 0 && !bp_done && m_exe == bp_at && m_gz == GAP) begin
        afull_hold = 5;
        bp_done = 1;
      end
      if (rst_at >= 0 && !rst_done && m_exe == rst_at && m_gz == GAP) begin
        rst_req = 1;
        rst_done = 1;
      end
      if (spam && $urandom_range(0, 7) == 0) begin
        start_req = 1;
        na_req = CBW'($urandom);
      end
      if (at_done && m_fin) begin
        start_req = 1;
        na_req = CBW'(na + 1);
      end
      tick();
    end
    rst_req = 0;
    start_req = 0;
    if (rst_done) begin
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_inst_w", 32'(inst_w), 32'(INST_NOP));
      chk("rst_l0_rd", 32'(l0_rd), 32'd0);
      chk("rst_ofifo_wr", 32'(ofifo_wr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
    end
    tick();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; num_act = '0; l0_empty = 1'b1; ofifo_afull = 1'b0;
    col_valid = '0;
    rst_req = 1;
    repeat (3) tick();
    rst_req = 0;
    tick();
    // Nominal pass.
    empty_mode = 0; afull_mode = 0;
    run_pass(4, -1, -1, 0, 0);
    // L0 starvation on alternate cycles.
    empty_mode = 1;
    run_pass(3, -1, -1, 0, 0);
    // Backpressure burst mid-execute.
    empty_mode = 0;
    run_pass(10, 3, -1, 0, 0);
    // Empty activation count.
    run_pass(0, -1, -1, 0, 0);
    // Reset after two of six execute issues, then a fresh nominal pass.
    run_pass(6, -1, 2, 0, 0);
    run_pass(4, -1, -1, 0, 0);
    // Starts while busy and in the done cycle are ignored.
    run_pass(5, -1, -1, 1, 1);
    // Randomized traffic.
    empty_mode = 2; afull_mode = 1;
    for (int p = 0; p < 12; p++) run_pass($urandom_range(0, 20), -1, -1, 1, p[0]);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_array_ctrl.md
Name: mac_array_ctrl

Overview:
- Sequences one kernel-load / execute pass of the 8x8 weight-stationary MAC array.
- Pulls kernel and activation vectors from the L0 input buffer (first-word-fall-through, FWFT) and drives the array's 2-bit inst_w.
- Gates the array's per-column valid outputs into the OFIFO write enables.
- Sits between the core top-level sequencer (start/done) and the L0 / mac_array / OFIFO datapath.

Parameters:
- row, 8, array rows; also the inst_w pipeline depth inside the array
- col, 8, array columns; number of kernel vectors per load
- cnt_bw, 8, width of the activation-vector count
- load_gap, 16, idle cycles after the last kernel vector (>= row+col) so weights settle before execute

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous reset, active-low (0 = reset)
- start  in  1  one-cycle pass request; ignored while busy=1
- num_act  in  cnt_bw  activation vectors to execute; sampled when start is accepted
- busy  out  1  high from start acceptance until the done cycle inclusive
- done  out  1  one-cycle pulse when the pass completes
- l0_empty  in  1  L0 has no word available
- l0_rd  out  1  pop L0; the FWFT word is on in_w in the same cycle
- inst_w  out  2  to mac_array: bit1 = execute, bit0 = kernel load
- ofifo_afull  in  1  OFIFO free entries <= row+col
- col_valid  in  col  per-column valid from mac_array
- ofifo_wr  out  col  per-column OFIFO write enable

Behaviour:
- Reset (reset==0 at a clk edge): state=IDLE; all counters cleared; busy=0, done=0, l0_rd=0, inst_w=2'b00, ofifo_wr=0. Reset mid-pass aborts immediately and sends no done.
- Issue rule: in an issuing state, l0_rd and the state's inst_w code are asserted in the same cycle, only when the issue condition holds. Otherwise l0_rd=0 and inst_w=00 (bubble); bubbles are legal anywhere.
- IDLE: when start=1, latch num_act into act_tgt, set busy=1, and go to KLOAD next cycle.
- KLOAD:
  - Issue condition: !l0_empty. Issued code is inst_w=01.
  - kcnt increments on each issue.
  - After the issue with kcnt==col-1, go to KGAP.
- KGAP: inst_w=00 for exactly load_gap cycles (gcnt), then go to EXEC. If act_tgt==0, go to DRAIN instead.
- EXEC:
  - Issue condition: !l0_empty && !ofifo_afull. Issued code is inst_w=10.
  - acnt increments on each issue.
  - After the issue with acnt==act_tgt-1, go to DRAIN.
- Output gating: ofifo_wr = col_valid in EXEC and DRAIN, and 0 in all other states.
- Completion counting: ocnt increments on each cycle with col_valid[col-1]=1 in EXEC or DRAIN.
- DRAIN: inst_w=00. When ocnt==act_tgt (including the cycle of the final increment), go to DONE.
- DONE: done=1, busy=1 for one cycle, then IDLE with busy=0. A start in the DONE cycle is ignored; back-to-back passes see one IDLE cycle minimum.
- Width rules: kcnt is clog2(col) bits; acnt and ocnt are cnt_bw bits; gcnt is clog2(load_gap+1) bits. No wrap is possible since act_tgt < 2^cnt_bw.
- Simultaneous events: l0_empty and ofifo_afull both high inside EXEC is a plain bubble. Counters never advance on a bubble. ofifo_afull is ignored in KLOAD because kernel loading produces no outputs.
- Invariant (bench assertion): inst_w is never 2'b11. inst_w==01 and inst_w==10 are never adjacent without at least load_gap 00-cycles between them.

Decomposition:
- Shared package mac_ctrl_pkg:
  - state enum IDLE, KLOAD, KGAP, EXEC, DRAIN, DONE
  - inst codes INST_NOP=2'b00, INST_KLD=2'b01, INST_EXE=2'b10
  - default row/col constants
- One sub-module, mac_issue_cnt: the enable-gated counter with terminal-count flag, instantiated for kcnt, gcnt, acnt and ocnt.
- FSM and output decode stay in mac_array_ctrl.

Test Plan:
- Nominal pass: L0 never empty, afull=0, num_act=4, start pulse → exactly 8 cycles inst_w=01 with l0_rd=1, then 16 cycles 00, then 4 cycles 10; done pulses one cycle after the 4th col_valid[7] pulse; busy is high throughout.
- L0 starvation: l0_empty high on alternate cycles during KLOAD and EXEC, num_act=3 → still exactly 8 kernel issues and 3 execute issues, with a bubble (inst_w=00, l0_rd=0) on every empty cycle.
- Backpressure: ofifo_afull held high for 5 cycles mid-EXEC → no 10 issues and no l0_rd during those 5 cycles; issuing resumes the cycle afull drops; total of 10 issues equals num_act.
- num_act=0: start → 8 kernel issues, 16 gap cycles, no execute issue, done within 2 cycles of gap end; ofifo_wr stays 0.
- Reset mid-EXEC after 2 of 6 issues: reset=0 for one edge → the next cycle shows busy=0, inst_w=00, l0_rd=0, ofifo_wr=0, done never pulses; a fresh start then runs a full nominal pass.
- start while busy and start during DONE → ignored; act_tgt stays unchanged (checked via issue count) and there is no second done.
